// File: rtl/vga_timing_prog.sv
// rtl/vga_timing_prog.sv - runtime-programmable VGA/DVI raster timing generator
// Counters run on an active timing set; a shadow set is copied in only at a frame wrap.
module vga_timing_prog #(
  parameter int WIDTH = 12,
  parameter int HSIZE = 800,
  parameter int HFP   = 840,
  parameter int HSP   = 968,
  parameter int HMAX  = 1056,
  parameter int VSIZE = 600,
  parameter int VFP   = 601,
  parameter int VSP   = 605,
  parameter int VMAX  = 628,
  parameter bit HSPP  = 1'b1,
  parameter bit VSPP  = 1'b1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  input  logic             cfg_commit,
  output logic             cfg_pending,
  output logic [WIDTH-1:0] hdata,
  output logic [WIDTH-1:0] vdata,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             sof,
  output logic             eol,
  output logic [15:0]      frame_cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // Pipe vector order: {hsync, vsync, de, sof, eol}; syncs reset to their idle level.
  localparam logic [4:0] PIPE_RST = {~HSPP, ~VSPP, 3'b000};

  localparam int I_HSIZE = 0;
  localparam int I_HFP   = 1;
  localparam int I_HSP   = 2;
  localparam int I_HMAX  = 3;
  localparam int I_VSIZE = 4;
  localparam int I_VFP   = 5;
  localparam int I_VSP   = 6;
  localparam int I_VMAX  = 7;

  function automatic logic [WIDTH-1:0] reg_default(input int idx);
    case (idx)
      I_HSIZE: reg_default = WIDTH'(HSIZE);
      I_HFP:   reg_default = WIDTH'(HFP);
      I_HSP:   reg_default = WIDTH'(HSP);
      I_HMAX:  reg_default = WIDTH'(HMAX);
      I_VSIZE: reg_default = WIDTH'(VSIZE);
      I_VFP:   reg_default = WIDTH'(VFP);
      I_VSP:   reg_default = WIDTH'(VSP);
      default: reg_default = WIDTH'(VMAX);
    endcase
  endfunction

  logic [WIDTH-1:0] shadow [8];
  logic [WIDTH-1:0] act    [8];
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             vis;
  logic [4:0]       raw;
  logic [4:0]       pipe [DELAY];

  // >= rather than == so a shrunken HMAX/VMAX can never strand the counters.
  assign h_wrap     = hdata >= act[I_HMAX] - ONE;
  assign v_wrap     = vdata >= act[I_VMAX] - ONE;
  assign frame_wrap = en && h_wrap && v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= reg_default(i);
        act[i]    <= reg_default(i);
      end
      cfg_pending <= 1'b0;
    end else begin
      if (frame_wrap && cfg_pending) begin
        for (int i = 0; i < 8; i++) act[i] <= shadow[i];
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
      if (cfg_wr) shadow[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdata     <= '0;
      vdata     <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (h_wrap) begin
        hdata <= '0;
        if (v_wrap) begin
          vdata     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          vdata <= vdata + ONE;
        end
      end else begin
        hdata <= hdata + ONE;
      end
    end
  end

  always_comb begin
    hs_act = (hdata >= act[I_HFP]) && (hdata < act[I_HSP]);
    vs_act = (vdata >= act[I_VFP]) && (vdata < act[I_VSP]);
    vis    = (hdata < act[I_HSIZE]) && (vdata < act[I_VSIZE]);
    raw    = {(en & hs_act) ^ ~HSPP,
              (en & vs_act) ^ ~VSPP,
              en & vis,
              en & (hdata == '0) & (vdata == '0),
              en & (hdata == act[I_HSIZE] - ONE) & (vdata < act[I_VSIZE])};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= PIPE_RST;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {hsync, vsync, de, sof, eol} = pipe[DELAY-1];

endmodule
